series_job_arbiter: RTL

Round-robin arbiter and sequencer that shares one series-evaluation datapath/controller pair among up to N_REQ requesters. It latches the winning requester's operand and drives the unit's start handshake. It waits for the unit's done, captures the result and returns it with a one-cycle acknowledge to the winner. It sits between the client blocks and the series unit's start/done/result interface.

---
 rtl/series_arb_pkg.sv | 16 +
 rtl/series_job_arbiter_rr_picker.sv | 34 +++
 rtl/series_job_arbiter.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/series_arb_pkg.sv
// Shared types and default parameters for the series-unit job arbiter.
package series_arb_pkg;

  localparam int DEF_N_REQ   = 4;
  localparam int DEF_DATA_W  = 16;
  localparam int DEF_TIMEOUT = 255;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GRANT = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    RESP  = 3'd4
  } arb_state_e;

endpackage

// File: rtl/series_job_arbiter_rr_picker.sv
// Combinational round-robin picker: first set req bit at or after rr_ptr, wrapping mod N_REQ.
module rr_picker #(
  parameter  int N_REQ = 4,
  localparam int IDW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   rr_ptr,
  output logic             valid,
  output logic [IDW-1:0]   idx
);

  logic [IDW:0]   sum  [N_REQ];
  logic [IDW-1:0] cand [N_REQ];

  // cand[gi] is the client gi positions after rr_ptr; the wrap is an explicit
  // subtract so non-power-of-two N_REQ works.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
    assign sum[gi]  = {1'b0, rr_ptr} + (IDW+1)'(gi);
    assign cand[gi] = (sum[gi] >= (IDW+1)'(N_REQ)) ?
                      IDW'(sum[gi] - (IDW+1)'(N_REQ)) : sum[gi][IDW-1:0];
  end

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[cand[k]]) begin
        valid = 1'b1;
        idx   = cand[k];
      end
    end
  end

endmodule

// File: rtl/series_job_arbiter.sv
// Round-robin arbiter/sequencer sharing one series unit among N_REQ clients.
// Define SERIES_ARB_TIMEOUT_EN to abort WAIT after TIMEOUT cycles with err=1.
module series_job_arbiter
  import series_arb_pkg::*;
#(
  parameter  int N_REQ   = DEF_N_REQ,
  parameter  int DATA_W  = DEF_DATA_W,
  parameter  int TIMEOUT = DEF_TIMEOUT,
  localparam int IDW     = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] x_in,
  output logic [N_REQ-1:0]        ack,
  output logic [DATA_W-1:0]       result,
  output logic                    err,
  output logic                    busy,
  output logic [IDW-1:0]          grant_id,
  output logic                    su_start,
  output logic [DATA_W-1:0]       su_x,
  input  logic                    su_done,
  input  logic [DATA_W-1:0]       su_result
);

  arb_state_e        state_q, state_d;
  logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]    grant_id_q, grant_id_d;
  logic [DATA_W-1:0] su_x_q, su_x_d;
  logic [DATA_W-1:0] result_q, result_d;

  logic              pick_valid;
  logic [IDW-1:0]    pick_idx;

  rr_picker #(.N_REQ(N_REQ)) u_picker (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .valid  (pick_valid),
    .idx    (pick_idx)
  );

`ifdef SERIES_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             err_q, err_d;
  logic             tmo_hit;

  // Leaving on the cycle the count would reach TIMEOUT gives exactly TIMEOUT WAIT cycles.
  assign tmo_hit = (tmo_cnt_q == CNT_W'(TIMEOUT - 1));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
`endif

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    su_x_d     = su_x_q;
    result_d   = result_q;
`ifdef SERIES_ARB_TIMEOUT_EN
    tmo_cnt_d  = tmo_cnt_q;
    err_d      = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (|req) state_d = GRANT;
      end
      GRANT: begin
        // All requesters may have dropped since IDLE; go back without a job.
        if (pick_valid) begin
          grant_id_d = pick_idx;
          su_x_d     = x_in[pick_idx*DATA_W +: DATA_W];
          state_d    = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        state_d = WAIT;
`ifdef SERIES_ARB_TIMEOUT_EN
        tmo_cnt_d = '0;
`endif
      end
      WAIT: begin
        if (su_done) begin
          result_d = su_result;
          state_d  = RESP;
`ifdef SERIES_ARB_TIMEOUT_EN
          err_d    = 1'b0;
        end else if (tmo_hit) begin
          result_d = '0;
          err_d    = 1'b1;
          state_d  = RESP;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
`endif
        end
      end
      RESP: begin
        rr_ptr_d = (grant_id_q == IDW'(N_REQ - 1)) ? '0 : grant_id_q + 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      su_x_q     <= '0;
      result_q   <= '0;
`ifdef SERIES_ARB_TIMEOUT_EN
      tmo_cnt_q  <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      su_x_q     <= su_x_d;
      result_q   <= result_d;
`ifdef SERIES_ARB_TIMEOUT_EN
      tmo_cnt_q  <= tmo_cnt_d;
      err_q      <= err_d;
`endif
    end
  end

  always_comb begin
    ack = '0;
    if (state_q == RESP) ack[grant_id_q] = 1'b1;
  end

`ifdef SERIES_ARB_TIMEOUT_EN
  assign err = (state_q == RESP) && err_q;
`else
  assign err = 1'b0;
`endif

  assign result   = result_q;
  assign busy     = (state_q != IDLE);
  assign grant_id = grant_id_q;
  assign su_start = (state_q == START);
  assign su_x     = su_x_q;

endmodule
